// File: rtl/hawk_axiwr_arb.sv
// Round-robin arbiter sharing one AXI write master among NREQ single-beat write
// requesters; latches the winner's payload, runs AW/W independently, returns B.
module hawk_axiwr_arb #(
  parameter int NREQ    = 3,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 512,
  parameter int BTO_CYC = 1024
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NREQ-1:0]            req_valid_i,
  input  logic [NREQ*ADDR_W-1:0]     req_addr_i,
  input  logic [NREQ*DATA_W-1:0]     req_data_i,
  input  logic [NREQ*DATA_W/8-1:0]   req_strb_i,
  output logic [NREQ-1:0]            req_ack_o,
  output logic [NREQ-1:0]            req_done_o,
  output logic                       req_err_o,
  output logic                       m_awvalid_o,
  output logic [ADDR_W-1:0]          m_awaddr_o,
  input  logic                       m_awready_i,
  output logic                       m_wvalid_o,
  output logic [DATA_W-1:0]          m_wdata_o,
  output logic [DATA_W/8-1:0]        m_wstrb_o,
  input  logic                       m_wready_i,
  input  logic                       m_bvalid_i,
  input  logic [1:0]                 m_bresp_i,
  output logic                       m_bready_o,
  output logic                       busy_o
);
  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [15:0] WD_LAST = 16'(BTO_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, XFER, WAIT_B} state_t;

  state_t              state_q;
  logic [IDX_W-1:0]    rr_ptr_q, gnt_q;
  logic                aw_done_q, w_done_q;
  logic [15:0]         wd_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [STRB_W-1:0]   strb_q;
  logic [NREQ-1:0]     ack_q, done_q;
  logic                err_q;

  logic [ADDR_W-1:0]   addr_arr [NREQ];
  logic [DATA_W-1:0]   data_arr [NREQ];
  logic [STRB_W-1:0]   strb_arr [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slot
      assign addr_arr[gi] = req_addr_i[gi*ADDR_W +: ADDR_W];
      assign data_arr[gi] = req_data_i[gi*DATA_W +: DATA_W];
      assign strb_arr[gi] = req_strb_i[gi*STRB_W +: STRB_W];
    end
  endgenerate

  // First pending requester at or after rr_ptr, wrapping NREQ-1 -> 0.
  logic             found_d;
  logic [IDX_W-1:0] pick_d;
  int               idx_d;
  always_comb begin
    found_d = 1'b0;
    pick_d  = '0;
    idx_d   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx_d = int'(rr_ptr_q) + k;
      if (idx_d >= NREQ) idx_d = idx_d - NREQ;
      if (!found_d && req_valid_i[idx_d]) begin
        found_d = 1'b1;
        pick_d  = IDX_W'(idx_d);
      end
    end
  end

  logic aw_hs, w_hs, b_fin;
  logic [IDX_W-1:0] rr_next;
  assign aw_hs   = (state_q == XFER) && !aw_done_q && m_awready_i;
  assign w_hs    = (state_q == XFER) && !w_done_q && m_wready_i;
  assign b_fin   = m_bvalid_i || (wd_q == WD_LAST);
  assign rr_next = (gnt_q == IDX_LAST) ? '0 : gnt_q + 1'b1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      gnt_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      wd_q      <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
      ack_q     <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      ack_q  <= '0;
      done_q <= '0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (found_d) begin
            gnt_q         <= pick_d;
            addr_q        <= addr_arr[pick_d];
            data_q        <= data_arr[pick_d];
            strb_q        <= strb_arr[pick_d];
            ack_q[pick_d] <= 1'b1;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
            state_q       <= XFER;
          end
        end
        XFER: begin
          if (aw_hs) aw_done_q <= 1'b1;
          if (w_hs)  w_done_q  <= 1'b1;
          if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
            wd_q    <= '0;
            state_q <= WAIT_B;
          end
        end
        WAIT_B: begin
          // A B response in the expiry cycle takes precedence over the timeout.
          if (b_fin) begin
            done_q[gnt_q] <= 1'b1;
            err_q         <= m_bvalid_i ? (m_bresp_i != 2'b00) : 1'b1;
            rr_ptr_q      <= rr_next;
            state_q       <= IDLE;
          end else begin
            wd_q <= wd_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ack_o   = ack_q;
  assign req_done_o  = done_q;
  assign req_err_o   = err_q;
  assign m_awvalid_o = (state_q == XFER) && !aw_done_q;
  assign m_wvalid_o  = (state_q == XFER) && !w_done_q;
  assign m_bready_o  = (state_q == WAIT_B);
  assign busy_o      = (state_q != IDLE);
  assign m_awaddr_o  = addr_q;
  assign m_wdata_o   = data_q;
  assign m_wstrb_o   = strb_q;
endmodule
